// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - byte-stream boot loader for the Hack instruction ROM
// Parses LEN / data words / CHK, writes ROM, and gates the computer's reset on checksum.
module hack_rom_loader #(
  parameter int ADDR_W    = 15,
  parameter int MAX_WORDS = 32768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO,
    S_WRITE, S_CHK_HI, S_CHK_LO, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        hi_byte;
  logic [15:0]       len;
  logic [15:0]       sum;
  logic [ADDR_W:0]   idx;
  logic              xfer;
  logic [15:0]       rx_word;
  logic [ADDR_W:0]   idx_inc;
  logic              last_word;
  logic              len_too_big;
  logic              chk_match;

  assign xfer        = rx_valid & rx_ready;
  assign rx_word     = {hi_byte, rx_data};
  assign idx_inc     = idx + 1'b1;
  // Index is one bit wider than the address so a full-size image ends without wrapping.
  assign last_word   = (32'(idx_inc) == 32'(len));
  assign len_too_big = (32'(rx_word) > 32'(MAX_WORDS));
  assign chk_match   = (rx_word == sum);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_req) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (rx_word == 16'd0) state_nxt = S_CHK_HI;
          else if (len_too_big) state_nxt = S_ERROR;
          else                  state_nxt = S_DAT_HI;
        end
      end
      S_DAT_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_DAT_LO;
      end
      S_DAT_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = last_word ? S_CHK_HI : S_DAT_HI;
      end
      S_CHK_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = S_CHK_LO;
      end
      S_CHK_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_nxt = chk_match ? S_DONE : S_ERROR;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      hi_byte   <= '0;
      len       <= '0;
      sum       <= '0;
      idx       <= '0;
    end else begin
      rom_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_req) begin
            cpu_reset <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
          end
        end
        S_LEN_HI, S_DAT_HI, S_CHK_HI: begin
          if (xfer) hi_byte <= rx_data;
        end
        S_LEN_LO: begin
          if (xfer) begin
            len <= rx_word;
            if (rx_word != 16'd0 && len_too_big) begin
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
        S_DAT_LO: begin
          // Address and data are registered so they stay put between write strobes.
          if (xfer) begin
            rom_we    <= 1'b1;
            rom_addr  <= idx[ADDR_W-1:0];
            rom_wdata <= rx_word;
          end
        end
        S_WRITE: begin
          sum <= sum + rom_wdata;
          idx <= idx_inc;
        end
        S_CHK_LO: begin
          if (xfer) begin
            busy <= 1'b0;
            if (chk_match) begin
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              error     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// tb/tb_hack_rom_loader.sv - directed bench for hack_rom_loader
// Image-level model predicts ROM writes and final status; a monitor checks every cycle.
module tb_hack_rom_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_req = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        rom_we;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        cpu_reset, busy, done, error;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  img[$];
  logic [30:0] exp_q[$];
  logic [15:0] shadow[0:31];
  int          m_nw, m_nbytes;
  logic        m_done, m_err;

  hack_rom_loader #(.ADDR_W(15), .MAX_WORDS(32768)) dut (
    .clk(clk), .reset(reset), .load_req(load_req),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Image-level model: parse LEN, list the writes, compare the additive checksum.
  task automatic model();
    int n;
    logic [15:0] s, w, chk;
    n = {img[0], img[1]};
    exp_q.delete();
    if (n > 32768) begin
      m_nw = 0; m_nbytes = 2; m_done = 1'b0; m_err = 1'b1;
    end else begin
      s = 16'h0;
      for (int k = 0; k < n; k++) begin
        w = {img[2+2*k], img[3+2*k]};
        exp_q.push_back({k[14:0], w});
        s = s + w;
      end
      chk = {img[2+2*n], img[3+2*n]};
      m_nw = n; m_nbytes = 4 + 2*n;
      m_done = (chk == s); m_err = (chk != s);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("cpu_reset_vs_done", {31'b0, cpu_reset}, {31'b0, ~done});
      if (rom_we) begin
        check("ready_low_in_write", {31'b0, rx_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          logic [30:0] e;
          e = exp_q.pop_front();
          check("rom_addr", {17'b0, rom_addr}, {17'b0, e[30:16]});
          check("rom_wdata", {16'b0, rom_wdata}, {16'b0, e[15:0]});
        end
        shadow[rom_addr[4:0]] = rom_wdata;
      end
    end
  end

  // Start a load, then stream bytes; stop_after >= 0 truncates the stream.
  task automatic run_load(input int max_gap, input int req_at, input int stop_after);
    int nsend, stall;
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("start_busy", {31'b0, busy}, 32'd1);
    check("start_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    check("start_done", {31'b0, done}, 32'd0);
    check("start_error", {31'b0, error}, 32'd0);
    nsend = (stop_after >= 0) ? stop_after : m_nbytes;
    for (int i = 0; i < nsend; i++) begin
      int g;
      g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      repeat (g) begin rx_valid = 1'b0; @(negedge clk); end
      rx_valid = 1'b1;
      rx_data  = img[i];
      if (i == req_at) load_req = 1'b1;
      stall = 0;
      while (!rx_ready && stall < 50) begin
        @(negedge clk);
        load_req = 1'b0;
        stall++;
      end
      if (stall >= 50) begin
        check("rx_ready_timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
      load_req = 1'b0;
      if (i >= 2 && i < 2 + 2*m_nw && (i % 2) == 1)
        check("we_latency", {31'b0, rom_we}, 32'd1);
    end
    if (stop_after < 0) begin
      check("end_done", {31'b0, done}, {31'b0, m_done});
      check("end_error", {31'b0, error}, {31'b0, m_err});
      check("end_cpu_reset", {31'b0, cpu_reset}, {31'b0, ~m_done});
      check("end_busy", {31'b0, busy}, 32'd0);
      check("writes_pending", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("rst_rom_we", {31'b0, rom_we}, 32'd0);
    check("rst_rom_addr", {17'b0, rom_addr}, 32'd0);
    check("rst_rom_wdata", {16'b0, rom_wdata}, 32'd0);
    check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    reset = 1'b1;

    img = '{8'h00, 8'h03, 8'h00, 8'h10, 8'hEA, 8'h87, 8'h00, 8'h01, 8'hEA, 8'h98};
    model();
    run_load(0, -1, -1);
    check("a_done", {31'b0, done}, 32'd1);
    check("a_rom0", {16'b0, shadow[0]}, 32'h0010);
    check("a_rom1", {16'b0, shadow[1]}, 32'hEA87);
    check("a_rom2", {16'b0, shadow[2]}, 32'h0001);

    img = '{8'h00, 8'h03, 8'h00, 8'h10, 8'hEA, 8'h87, 8'h00, 8'h01, 8'h00, 8'h00};
    model();
    run_load(0, -1, -1);
    check("badchk_error", {31'b0, error}, 32'd1);
    check("badchk_cpu_reset", {31'b0, cpu_reset}, 32'd1);

    img = '{8'h00, 8'h00, 8'h00, 8'h00};
    model();
    run_load(0, -1, -1);
    check("n0_done", {31'b0, done}, 32'd1);

    img = '{8'h80, 8'h01};
    model();
    run_load(0, -1, -1);
    check("toolong_error", {31'b0, error}, 32'd1);

    for (int k = 0; k < 3; k++) shadow[k] = 16'hDEAD;
    img = '{8'h00, 8'h03, 8'h00, 8'h10, 8'hEA, 8'h87, 8'h00, 8'h01, 8'hEA, 8'h98};
    model();
    run_load(5, 4, -1);
    check("gap_rom0", {16'b0, shadow[0]}, 32'h0010);
    check("gap_rom1", {16'b0, shadow[1]}, 32'hEA87);
    check("gap_rom2", {16'b0, shadow[2]}, 32'h0001);

    img = '{8'h00, 8'h04, 8'h12, 8'h34, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h92, 8'h33};
    model();
    run_load(0, -1, 6);
    #2 reset = 1'b0;
    #1;
    check("abort_rom_we", {31'b0, rom_we}, 32'd0);
    check("abort_rom_addr", {17'b0, rom_addr}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    check("abort_rx_ready", {31'b0, rx_ready}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    check("req_under_reset_busy", {31'b0, busy}, 32'd0);
    load_req = 1'b0;
    reset = 1'b1;
    model();
    run_load(3, 7, -1);
    check("b_done", {31'b0, done}, 32'd1);
    check("b_rom3", {16'b0, shadow[3]}, 32'h8000);

    img = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h01, 8'h01, 8'hAC, 8'hCE};
    model();
    run_load(1, 3, -1);
    check("c_done", {31'b0, done}, 32'd1);
    check("c_rom0", {16'b0, shadow[0]}, 32'hABCD);
    check("c_rom1", {16'b0, shadow[1]}, 32'h0101);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Byte-stream boot loader that sits directly upstream of the Hack computer.
- Receives a program image over a valid/ready byte interface and writes it word-by-word into the instruction ROM write port.
- Holds the computer in reset for the whole load, then releases it to execute from address 0.
- Verifies a 16-bit additive checksum; on mismatch the computer stays in reset and an error flag is raised.

Parameters:
ADDR_W, 15, ROM address width (Hack ROM = 32K words)
MAX_WORDS, 32768, largest accepted image length in words

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
load_req  in  1  single-cycle pulse; starts a new load from IDLE, DONE or ERROR
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready)
rom_we  out  1  ROM write strobe, one cycle per word
rom_addr  out  ADDR_W  ROM write address
rom_wdata  out  16  ROM write data
cpu_reset  out  1  active-high reset to the computer
busy  out  1  load in progress
done  out  1  last load succeeded (sticky until next load_req)
error  out  1  last load failed (sticky until next load_req)

Behaviour:
- Reset (reset=0, asynchronous) values:
  - state=IDLE; rx_ready=0, rom_we=0, rom_addr=0, rom_wdata=0.
  - cpu_reset=1, busy=0, done=0, error=0.
  - The computer stays held until a successful load.
- Image format (all words big-endian, high byte first):
  - LEN word N.
  - N data words.
  - CHK word = 16-bit wrap-around sum of the N data words.
- States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK_HI, CHK_LO, DONE, ERROR.
- IDLE/DONE/ERROR:
  - rx_ready=0.
  - load_req -> LEN_HI; next cycle cpu_reset=1, busy=1, done=0, error=0; addr and sum cleared.
- LEN_HI/LEN_LO, DAT_HI/DAT_LO, CHK_HI/CHK_LO:
  - rx_ready=1.
  - Advance only on a transfer; no transfer means hold the state (stalls of any length allowed).
- After LEN_LO:
  - N==0 -> CHK_HI.
  - N>MAX_WORDS -> ERROR.
  - Otherwise -> DAT_HI.
- DAT_LO transfer -> WRITE.
- WRITE (exactly 1 cycle):
  - rx_ready=0; rom_we=1 with rom_addr = current index and rom_wdata = assembled word.
  - sum += word (mod 2^16).
  - Then increment index; if index == N -> CHK_HI, else -> DAT_HI.
- Write latency: rom_we asserts the cycle after the low data byte transfer.
- Address rules: rom_addr holds its last value when rom_we=0. Index counter is ADDR_W+1 bits so N=MAX_WORDS is reachable without wrap.
- CHK_LO transfer:
  - Match -> DONE: cpu_reset=0, busy=0, done=1.
  - Mismatch -> ERROR: cpu_reset=1, busy=0, error=1.
- ERROR keeps the computer in reset; ROM contents are not cleared.
- load_req while busy: ignored.
- load_req in the same cycle as reset=0: reset wins.
- Reset mid-load: immediate return to IDLE with reset values; partially written ROM is left as is; cpu_reset=1.
- Bytes offered while rx_ready=0 are not consumed; the upstream must hold them.

Test Plan:
- Reset then load_req; send 00 03 | 00 10 | EA 87 | 00 01 | EA 98 -> rom_we pulses at addr 0,1,2 with 0x0010, 0xEA87, 0x0001; done=1, cpu_reset falls the cycle after the last byte; Max.hack-style run follows.
- Same image with CHK 00 00 -> error=1, done=0, cpu_reset stays 1, three ROM writes still occur.
- N=0: send 00 00 00 00 -> no rom_we, done=1; N=0x8001 -> ERROR directly after LEN_LO, no writes.
- Random rx_valid gaps (0-5 idle cycles) and rx_valid asserted during WRITE -> byte held, not lost; identical ROM contents to the no-gap run.
- Assert reset=0 after the 2nd data word -> outputs reset values asynchronously; a new load_req then full image -> addresses restart at 0, done=1.
- load_req pulses during the load -> ignored; a second load after DONE clears done, re-asserts cpu_reset, and overwrites ROM.
